// File: rtl/debug_readout.sv
// ----------------------------------------------------------------------------
// debug_readout
// Takes a coherent snapshot of the pipeline debug words and streams it to the
// host as one framed packet. The packet is a header word followed by
// NUM_WORDS data words. A snapshot is taken on a host request or on the
// auto-snapshot timer. A trigger that arrives while a frame is in flight is
// dropped and counted. It is never queued.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   debug_words_i   NUM_WORDS x 32-bit debug words (word k at [32k+31:32k])
//   snap_req_i      single-cycle host snapshot request
//   period_i        auto-snapshot period in cycles (0 = auto mode off)
//   m_data_o/m_vld_o/m_rdy_i/m_last_o   32-bit valid/ready output stream
//   busy_o          high while a frame is pending or being sent
//   seq_o           sequence number of the next frame
//   drop_cnt_o      saturating count of dropped triggers
// ----------------------------------------------------------------------------
module debug_readout #(
    parameter int unsigned NUM_WORDS    = 3,
    parameter int unsigned PERIOD_WIDTH = 24,
    parameter logic [7:0]  MAGIC        = 8'hDB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*NUM_WORDS-1:0]   debug_words_i,
    input  logic                      snap_req_i,
    input  logic [PERIOD_WIDTH-1:0]   period_i,
    output logic [31:0]               m_data_o,
    output logic                      m_vld_o,
    input  logic                      m_rdy_i,
    output logic                      m_last_o,
    output logic                      busy_o,
    output logic [7:0]                seq_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int unsigned   IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]    NW8      = 8'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [PERIOD_WIDTH-1:0]       r_timer;
    logic [NUM_WORDS-1:0][31:0]    r_snap;
    logic [IDX_W-1:0]              r_idx;
    logic [7:0]                    r_seq;
    logic [15:0]                   r_drop_cnt;

    logic                          w_expire;
    logic                          w_trig;
    logic                          w_is_last;

    // '>=' rather than '==' so that shrinking period_i below the current
    // timer value still expires at the next compare instead of wrapping.
    assign w_expire  = (period_i != '0) && (r_timer >= (period_i - PERIOD_WIDTH'(1)));
    assign w_trig    = snap_req_i | w_expire;
    assign w_is_last = (r_state == DATA) && (r_idx == LAST_IDX);

    // Auto-snapshot timer: runs in every state, held at zero when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (period_i == '0) begin
            r_timer <= '0;
        end else if (w_expire) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + PERIOD_WIDTH'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stream outputs. Outputs depend only on registered state,
    // so data and last hold steady while the sink stalls.
    always_comb begin
        w_state_nxt = r_state;
        m_data_o    = '0;
        m_last_o    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                m_data_o = {MAGIC, r_seq, 8'h00, NW8};
                if (m_rdy_i) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                m_data_o = r_snap[r_idx];
                m_last_o = w_is_last;
                if (m_rdy_i && w_is_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot, word index, sequence number and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= '0;
            r_idx      <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_trig) begin
                r_snap <= debug_words_i;
            end
            if (r_state == HDR && m_rdy_i) begin
                r_idx <= '0;
            end
            if (r_state == DATA && m_rdy_i) begin
                if (w_is_last) begin
                    r_seq <= r_seq + 8'd1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            // Any trigger outside IDLE is lost. This includes one that lands
            // on the final handshake, which keeps an idle cycle between frames.
            if (w_trig && r_state != IDLE && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign m_vld_o    = (r_state != IDLE);
    assign busy_o     = (r_state != IDLE);
    assign seq_o      = r_seq;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/debug_readout.md
Name: debug_readout

Overview:
- Reader-side counterpart to the pipeline debug monitor. Takes a coherent snapshot of the monitor's debug words and streams it to the host over a 32-bit valid/ready stream.
- A snapshot is taken on host request or periodically, and each snapshot is sent as one framed packet: a header word, then the data words.
- The block sits between the monitor outputs and the host-side stream bridge (UART/AXIS adapter).
- A trigger that arrives while a frame is in flight is dropped and counted, never queued.

Parameters:
- NUM_WORDS, 3, number of 32-bit debug words per snapshot (1..255).
- PERIOD_WIDTH, 24, width of the auto-snapshot period input and of the internal timer.
- MAGIC, 8'hDB, header marker byte.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- debug_words_i  input  32*NUM_WORDS  debug words; word k is bits [32k+31:32k].
- snap_req_i  input  1  single-cycle snapshot request from the host.
- period_i  input  PERIOD_WIDTH  auto-snapshot period in cycles; 0 disables auto mode.
- m_data_o  output  32  stream data.
- m_vld_o  output  1  stream valid.
- m_rdy_i  input  1  stream ready.
- m_last_o  output  1  marks the final word of a frame.
- busy_o  output  1  high while a frame is pending or being sent (state is not IDLE).
- seq_o  output  8  sequence number of the next frame.
- drop_cnt_o  output  16  count of dropped triggers; saturates at 16'hFFFF.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0; state goes to IDLE; timer, seq and drop_cnt clear.
  - A frame in progress is aborted and no m_last_o is emitted.
  - Reset has priority over every other event.
- Trigger definition:
  - trig = snap_req_i OR timer_expire.
  - If both occur in the same cycle, they form one trigger and nothing is counted as dropped.
- Timer:
  - When period_i == 0, the timer is held at 0 and never expires.
  - Otherwise it increments every cycle in every state. When it reaches period_i-1 it asserts timer_expire for one cycle and reloads to 0.
  - A change to period_i takes effect from the next compare.
  - The first expiry occurs period_i cycles after period_i becomes nonzero with the timer at 0.
- State machine: IDLE -> HDR -> DATA -> IDLE.
  - IDLE, trig at edge T:
    - snapshot registers capture debug_words_i as sampled at edge T;
    - m_vld_o is high from cycle T+1;
    - state goes to HDR.
  - HDR:
    - m_data_o = {MAGIC, seq[7:0], 8'h00, NUM_WORDS[7:0]} and m_last_o = 0;
    - on m_vld_o & m_rdy_i, go to DATA with idx = 0.
  - DATA:
    - m_data_o = snapshot[idx];
    - m_last_o = 1 when idx == NUM_WORDS-1;
    - on a handshake, idx increments, or on the last word: seq increments (wrapping 8'hFF -> 8'h00), m_vld_o drops, and state goes to IDLE.
- Stream hold: while m_vld_o is high and m_rdy_i is low, m_data_o and m_last_o hold stable and m_vld_o stays high.
- Throughput: m_vld_o stays high across consecutive words within a frame, so a frame takes NUM_WORDS+1 beats with no bubbles when m_rdy_i is held high.
- Frame gap: there is at least one IDLE cycle between frames. A trig in the same cycle as the last handshake is a drop.
- Drops: trig in any state other than IDLE increments drop_cnt by 1, saturating at 16'hFFFF. The snapshot is unaffected.
- Snapshot stability: debug_words_i changes after capture do not alter the frame in flight.
- busy_o = (state != IDLE). seq_o is the registered seq.

Test Plan:
- NUM_WORDS=3, period_i=0, debug_words_i={32'h3,32'h2,32'h1}, one-cycle snap_req_i, m_rdy_i=1 -> beats 32'hDB000003, 1, 2, 3 on consecutive cycles; m_last_o only on the 4th beat; seq_o goes 0 -> 1; busy_o low after the frame.
- Same trigger, then m_rdy_i toggling 1,0,0,1..., and debug_words_i changed to all 32'hFFFFFFFF right after capture -> data holds stable through every stall; the frame still carries 1, 2, 3; no word is lost or duplicated.
- snap_req_i pulsed 2 cycles after the first trigger while busy -> drop_cnt_o = 1; only one frame is emitted.
- period_i=10, m_rdy_i=1 -> headers start 10 cycles apart with seq 0, 1, 2...; in the cycle where the timer expires, also pulse snap_req_i -> exactly one frame is sent and drop_cnt_o is unchanged.
- Force seq to 255 through 256 frames -> header byte[23:16] goes FF then 00. Force 65,536+ drops -> drop_cnt_o saturates at FFFF.
- Assert rst during the DATA phase (idx=1) -> the next cycle has m_vld_o=0, busy_o=0, seq_o=0, drop_cnt_o=0; a fresh snap_req_i then produces a complete frame with seq 0.
